plab4_net_tdm_ring_link: RTL

//   One physical ring link shared by p_num_domains security domains using

---
 rtl/plab4_net_tdm_ring_link.sv | 105 ++++++++++
 1 files changed

// File: rtl/plab4_net_tdm_ring_link.sv
// plab4_net_tdm_ring_link: N-domain TDM ring link
// Per-domain FIFOs drained by a free-running slot scheduler with guard cycles.
module plab4_net_tdm_ring_link #(
  parameter int p_msg_nbits    = 41,
  parameter int p_num_domains  = 2,
  parameter int p_depth        = 2,
  parameter int p_slot_cycles  = 4,
  parameter int p_guard_cycles = 1,
  localparam int c_dom_nbits  =
    (p_num_domains > 1) ? $clog2(p_num_domains) : 1,
  localparam int c_slot_nbits =
    (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1,
  localparam int c_ptr_nbits  =
    (p_depth > 1) ? $clog2(p_depth) : 1,
  localparam int c_cnt_nbits  = $clog2(p_depth + 1),
  localparam int c_bus_nbits  = p_num_domains * p_msg_nbits
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [p_num_domains-1:0] in_val,
  output logic [p_num_domains-1:0] in_rdy,
  input  logic [c_bus_nbits-1:0]   in_msg,
  output logic                     out_val,
  input  logic [p_num_domains-1:0] out_rdy,
  output logic [p_msg_nbits-1:0]   out_msg,
  output logic [c_dom_nbits-1:0]   out_dom,
  output logic [c_dom_nbits-1:0]   cur_dom,
  output logic [c_slot_nbits-1:0]  slot_cnt
);

  localparam logic [c_slot_nbits-1:0] c_slot_last =
    c_slot_nbits'(p_slot_cycles - 1);
  localparam logic [c_dom_nbits-1:0] c_dom_last =
    c_dom_nbits'(p_num_domains - 1);
  localparam logic [c_slot_nbits:0] c_win =
    (c_slot_nbits + 1)'(p_slot_cycles - p_guard_cycles);
  localparam logic [c_ptr_nbits-1:0] c_ptr_last =
    c_ptr_nbits'(p_depth - 1);
  localparam logic [c_cnt_nbits-1:0] c_cnt_full =
    c_cnt_nbits'(p_depth);

  logic                     window;
  logic [p_num_domains-1:0] empty;
  logic [p_num_domains-1:0] full;
  logic [p_num_domains-1:0] pop;
  logic [p_msg_nbits-1:0]   head_msg [p_num_domains];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
      cur_dom  <= '0;
    end else if (slot_cnt == c_slot_last) begin
      slot_cnt <= '0;
      cur_dom  <= (cur_dom == c_dom_last) ? '0 : cur_dom + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // extra bit so a guard-free window of S cycles still compares correctly
  assign window  = ({1'b0, slot_cnt} < c_win);
  assign out_val = reset && window && !empty[cur_dom];
  assign out_msg = head_msg[cur_dom];
  assign out_dom = cur_dom;

  for (genvar d = 0; d < p_num_domains; d++) begin : g_dom
    logic [p_msg_nbits-1:0] mem [p_depth];
    logic [c_ptr_nbits-1:0] head;
    logic [c_ptr_nbits-1:0] tail;
    logic [c_cnt_nbits-1:0] cnt;
    logic                   wr;

    assign empty[d]    = (cnt == '0);
    assign full[d]     = (cnt == c_cnt_full);
    assign in_rdy[d]   = reset && !full[d];
    assign wr          = in_val[d] && in_rdy[d];
    assign pop[d]      = out_val && out_rdy[d]
                      && (cur_dom == c_dom_nbits'(d));
    assign head_msg[d] = mem[head];

    always_ff @(posedge clk) begin
      if (wr)
        mem[tail] <= in_msg[d*p_msg_nbits +: p_msg_nbits];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (wr)
          tail <= (tail == c_ptr_last) ? '0 : tail + 1'b1;
        if (pop[d])
          head <= (head == c_ptr_last) ? '0 : head + 1'b1;
        case ({wr, pop[d]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule
